// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller for a FIFO built around an external
// dual-port RAM with a registered read port (1-cycle read latency).
// Optional feature: define FIFO_ALMOST_FLAGS_EN to add the AF_LEVEL/AE_LEVEL
// parameters and the almost_full/almost_empty outputs.
module fifo_ctrl #(
  parameter int data_width    = 8,
  parameter int address_width = 4,
  parameter int RAM_size      = 16
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  parameter int AF_LEVEL      = RAM_size - 2,
  parameter int AE_LEVEL      = 2
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [data_width-1:0]    push_data,
  input  logic                     pop,
  output logic [data_width-1:0]    pop_data,
  output logic                     pop_valid,
  output logic                     full,
  output logic                     empty,
  output logic [address_width:0]   count,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     ram_wr_en,
  output logic                     ram_rd_en,
  output logic [address_width-1:0] ram_wr_addr,
  output logic [address_width-1:0] ram_rd_addr,
  output logic [data_width-1:0]    ram_data_in,
  input  logic [data_width-1:0]    ram_data_out
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic                     almost_full,
  output logic                     almost_empty
`endif
);

  // The pointer scheme only works when the depth is a power of two matching the address width.
  if (RAM_size != (2 ** address_width)) begin : gDepthCheck
    $error("fifo_ctrl: RAM_size must equal 2**address_width");
  end

  logic [address_width:0] wrPtr_q, wrPtr_d;
  logic [address_width:0] rdPtr_q, rdPtr_d;
  logic                   popValid_q, popValid_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;
  logic                   acceptPush;
  logic                   acceptPop;

  // Status flags from the extra-MSB pointer pair; pointers are zero in reset so flags follow.
  always_comb begin
    empty = (wrPtr_q == rdPtr_q);
    full  = (wrPtr_q[address_width-1:0] == rdPtr_q[address_width-1:0]) &&
            (wrPtr_q[address_width] != rdPtr_q[address_width]);
    count = wrPtr_q - rdPtr_q;
  end

  // Accept terms; rst_n gates them so no RAM strobe escapes while reset is held.
  always_comb begin
    acceptPop  = rst_n & pop & ~empty;
    acceptPush = rst_n & push & (~full | acceptPop);
  end

  // Next-state: advance pointers on accepted requests, latch sticky error flags.
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    popValid_d  = acceptPop;
    overflow_d  = overflow_q | (push & ~acceptPush);
    underflow_d = underflow_q | (pop & ~acceptPop);
    if (acceptPush) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (acceptPop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
  end

  // State registers; asynchronous reset discards all contents immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      popValid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      popValid_q  <= popValid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // RAM interface and registered outputs; read data comes straight from the RAM's output register.
  always_comb begin
    ram_wr_en   = acceptPush;
    ram_rd_en   = acceptPop;
    ram_wr_addr = wrPtr_q[address_width-1:0];
    ram_rd_addr = rdPtr_q[address_width-1:0];
    ram_data_in = push_data;
    pop_data    = ram_data_out;
    pop_valid   = popValid_q;
    overflow    = overflow_q;
    underflow   = underflow_q;
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  localparam logic [address_width:0] AfLevel = AF_LEVEL[address_width:0];
  localparam logic [address_width:0] AeLevel = AE_LEVEL[address_width:0];

  // Threshold flags straight off the occupancy count.
  always_comb begin
    almost_full  = (count >= AfLevel);
    almost_empty = (count <= AeLevel);
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: self-checking bench for fifo_ctrl with a behavioural RAM and
// a queue-based reference model of FIFO contents and sticky flags.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic [7:0] pop_data;
  logic       pop_valid, full, empty, overflow, underflow;
  logic [4:0] count;
  logic       ram_wr_en, ram_rd_en;
  logic [3:0] ram_wr_addr, ram_rd_addr;
  logic [7:0] ram_data_in;
  logic [7:0] ram_data_out = 8'h00;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic       almost_full, almost_empty;
`endif

  logic [7:0] mem [16];

  int         tests = 0;
  int         failures = 0;

  logic [7:0] model [$];
  logic       expValid = 1'b0;
  logic [7:0] expData = 8'h00;
  logic       expOvf = 1'b0;
  logic       expUdf = 1'b0;
  int         wrCount = 0;
  int         rdCount = 0;
  logic       predPush = 1'b0;
  logic       predPop = 1'b0;

  fifo_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push),
    .push_data    (push_data),
    .pop          (pop),
    .pop_data     (pop_data),
    .pop_valid    (pop_valid),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .ram_wr_en    (ram_wr_en),
    .ram_rd_en    (ram_rd_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_rd_addr  (ram_rd_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // External dual-port RAM with registered read port.
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_data_in;
    if (ram_rd_en) ram_data_out <= mem[ram_rd_addr];
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle's request at the falling edge and predict what gets accepted.
  task automatic applyStimulus(input logic p, input logic [7:0] d, input logic o);
    @(negedge clk);
    push = p;
    push_data = d;
    pop = o;
    #1;
    predPop  = o && (model.size() > 0);
    predPush = p && ((model.size() < 16) || predPop);
  endtask

  // Let the rising edge happen and update the reference model from the predictions.
  task automatic advance();
    @(posedge clk);
    if (predPop) begin
      expData = model.pop_front();
      rdCount++;
    end
    expValid = predPop;
    if (predPush) begin
      model.push_back(push_data);
      wrCount++;
    end
    if (push && !predPush) expOvf = 1'b1;
    if (pop && !predPop) expUdf = 1'b1;
    #1;
  endtask

  // Hold reset for two cycles and clear the model.
  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    model.delete();
    expValid = 1'b0;
    expOvf = 1'b0;
    expUdf = 1'b0;
    wrCount = 0;
    rdCount = 0;
    predPush = 1'b0;
    predPop = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    push = 1'b1;
    pop = 1'b1;
    push_data = 8'h33;
    #1;
    tests++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
    tests++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    tests++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    tests++; if (ram_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_en: got %b expected 0", ram_wr_en); end
    tests++; if (ram_rd_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_en: got %b expected 0", ram_rd_en); end
    @(posedge clk);
    #1;
    tests++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL reset_ignore_push: got %0d expected 0", count); end
    tests++; if (pop_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_pop_valid: got %b expected 0", pop_valid); end
    tests++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("[TB] FAIL reset_sticky: got %b expected 00", {overflow, underflow}); end
`ifdef FIFO_ALMOST_FLAGS_EN
    tests++; if ({almost_full, almost_empty} !== 2'b01) begin failures++; $display("[TB] FAIL reset_almost: got %b expected 01", {almost_full, almost_empty}); end
`endif
    applyReset();
  endtask

  task automatic test_fill_drain();
    applyReset();
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
      advance();
    end
    tests++; if (full !== 1'b1) begin failures++; $display("[TB] FAIL fill_full: got %b expected 1", full); end
    tests++; if (count !== 5'd16) begin failures++; $display("[TB] FAIL fill_count: got %0d expected 16", count); end
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      advance();
      tests++; if (pop_valid !== 1'b1 || pop_data !== 8'(i)) begin failures++; $display("[TB] FAIL drain_data: got valid=%b data=%h expected valid=1 data=%h", pop_valid, pop_data, 8'(i)); end
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    advance();
    tests++; if (empty !== 1'b1 || pop_valid !== 1'b0) begin failures++; $display("[TB] FAIL drain_empty: got empty=%b valid=%b expected empty=1 valid=0", empty, pop_valid); end
  endtask

  task automatic test_overflow();
    applyReset();
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 8'(i * 3), 1'b0);
      advance();
    end
    applyStimulus(1'b1, 8'hAA, 1'b0);
    tests++; if (ram_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL ovf_wr_en: got %b expected 0", ram_wr_en); end
    advance();
    tests++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); end
    tests++; if (count !== 5'd16) begin failures++; $display("[TB] FAIL ovf_count: got %0d expected 16", count); end
    applyStimulus(1'b0, 8'h00, 1'b1);
    advance();
    tests++; if (pop_data !== 8'd3) begin failures++; $display("[TB] FAIL ovf_oldest: got %h expected 03", pop_data); end
    for (int i = 2; i <= 16; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      advance();
    end
    tests++; if (pop_data !== 8'd48 || empty !== 1'b1 || overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_tail: got data=%h empty=%b ovf=%b expected data=30 empty=1 ovf=1", pop_data, empty, overflow); end
  endtask

  task automatic test_underflow();
    applyReset();
    applyStimulus(1'b0, 8'h00, 1'b1);
    tests++; if (ram_rd_en !== 1'b0) begin failures++; $display("[TB] FAIL udf_rd_en: got %b expected 0", ram_rd_en); end
    advance();
    tests++; if (pop_valid !== 1'b0) begin failures++; $display("[TB] FAIL udf_valid: got %b expected 0", pop_valid); end
    tests++; if (underflow !== 1'b1) begin failures++; $display("[TB] FAIL udf_flag: got %b expected 1", underflow); end
    applyStimulus(1'b1, 8'h77, 1'b1);
    tests++; if ({ram_wr_en, ram_rd_en} !== 2'b10) begin failures++; $display("[TB] FAIL udf_pushpop_en: got %b expected 10", {ram_wr_en, ram_rd_en}); end
    advance();
    tests++; if (count !== 5'd1 || pop_valid !== 1'b0) begin failures++; $display("[TB] FAIL udf_pushpop_count: got count=%0d valid=%b expected count=1 valid=0", count, pop_valid); end
  endtask

  task automatic test_wrap();
    logic [7:0] writeSeq;
    logic [7:0] readSeq;
    applyReset();
    writeSeq = 8'd1;
    readSeq = 8'd1;
    for (int round = 0; round < 2; round++) begin
      for (int i = 0; i < 10; i++) begin
        applyStimulus(1'b1, writeSeq, 1'b0);
        tests++; if (int'(ram_wr_addr) !== (wrCount % 16) || full !== 1'b0) begin failures++; $display("[TB] FAIL wrap_wr: got addr=%0d full=%b expected addr=%0d full=0", ram_wr_addr, full, wrCount % 16); end
        advance();
        writeSeq++;
      end
      for (int i = 0; i < 10; i++) begin
        applyStimulus(1'b0, 8'h00, 1'b1);
        tests++; if (int'(ram_rd_addr) !== (rdCount % 16)) begin failures++; $display("[TB] FAIL wrap_rd_addr: got %0d expected %0d", ram_rd_addr, rdCount % 16); end
        advance();
        tests++; if (pop_data !== readSeq) begin failures++; $display("[TB] FAIL wrap_data: got %h expected %h", pop_data, readSeq); end
        readSeq++;
      end
    end
  endtask

  task automatic test_full_simultaneous();
    applyReset();
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 8'(8'h80 + i), 1'b0);
      advance();
    end
    applyStimulus(1'b1, 8'h55, 1'b1);
    tests++; if ({ram_wr_en, ram_rd_en} !== 2'b11) begin failures++; $display("[TB] FAIL fullsim_en: got %b expected 11", {ram_wr_en, ram_rd_en}); end
    advance();
    tests++; if (count !== 5'd16) begin failures++; $display("[TB] FAIL fullsim_count: got %0d expected 16", count); end
    tests++; if (pop_valid !== 1'b1 || pop_data !== 8'h81) begin failures++; $display("[TB] FAIL fullsim_oldest: got valid=%b data=%h expected valid=1 data=81", pop_valid, pop_data); end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      advance();
    end
    tests++; if (pop_data !== 8'h55 || overflow !== 1'b0) begin failures++; $display("[TB] FAIL fullsim_tail: got data=%h ovf=%b expected data=55 ovf=0", pop_data, overflow); end
  endtask

  task automatic test_reset_midstream();
    applyReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
      advance();
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    advance();
    tests++; if (count !== 5'd7 || pop_valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_pre: got count=%0d valid=%b expected count=7 valid=1", count, pop_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (empty !== 1'b1 || count !== 5'd0 || pop_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_async: got empty=%b count=%0d valid=%b expected empty=1 count=0 valid=0", empty, count, pop_valid); end
    model.delete();
    expValid = 1'b0;
    wrCount = 0;
    rdCount = 0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h99, 1'b0);
    tests++; if (ram_wr_en !== 1'b1 || ram_wr_addr !== 4'd0) begin failures++; $display("[TB] FAIL mid_first_addr: got en=%b addr=%0d expected en=1 addr=0", ram_wr_en, ram_wr_addr); end
    advance();
  endtask

`ifdef FIFO_ALMOST_FLAGS_EN
  task automatic test_almost_flags();
    applyReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
      advance();
      tests++; if (almost_full !== (model.size() >= 14) || almost_empty !== (model.size() <= 2)) begin failures++; $display("[TB] FAIL almost_flags: got af=%b ae=%b expected af=%b ae=%b at size %0d", almost_full, almost_empty, model.size() >= 14, model.size() <= 2, model.size()); end
    end
  endtask
`endif

  task automatic test_random();
    logic p, o;
    applyReset();
    for (int i = 0; i < 400; i++) begin
      p = ($urandom_range(0, 99) < ((i < 200) ? 70 : 30));
      o = ($urandom_range(0, 99) < ((i < 200) ? 30 : 70));
      applyStimulus(p, 8'($urandom), o);
      tests++; if ({ram_wr_en, ram_rd_en} !== {predPush, predPop}) begin failures++; $display("[TB] FAIL rand_strobes: got %b expected %b", {ram_wr_en, ram_rd_en}, {predPush, predPop}); end
      tests++; if (int'(count) !== model.size() || full !== (model.size() == 16) || empty !== (model.size() == 0)) begin failures++; $display("[TB] FAIL rand_status: got count=%0d full=%b empty=%b expected count=%0d", count, full, empty, model.size()); end
      tests++; if (pop_valid !== expValid || (expValid && pop_data !== expData)) begin failures++; $display("[TB] FAIL rand_pop: got valid=%b data=%h expected valid=%b data=%h", pop_valid, pop_data, expValid, expData); end
      tests++; if ({overflow, underflow} !== {expOvf, expUdf}) begin failures++; $display("[TB] FAIL rand_sticky: got %b expected %b", {overflow, underflow}, {expOvf, expUdf}); end
      advance();
    end
  endtask

  // Run every scenario in sequence, then report.
  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_wrap();
    test_full_simultaneous();
    test_reset_midstream();
`ifdef FIFO_ALMOST_FLAGS_EN
    test_almost_flags();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
